// File: rtl/sipo_pkg.sv
// sipo_pkg: shared types, default word width and parity helper for the serial link.
package sipo_pkg;

    typedef enum logic {ST_EMPTY, ST_FULL} hold_st_t;

    localparam int SIPO_WIDTH = 8;

    function automatic logic even_parity(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/sipo_bitcnt.sv
// sipo_bitcnt: wrapping bit counter with enable, clear and terminal-count flag.
module sipo_bitcnt #(
    parameter int MAX   = 7,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    assign tc = cnt == CNT_W'(MAX);

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en)
            cnt <= tc ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/sipo_rx.sv
// sipo_rx: serial-in/parallel-out receiver, MSB first, with holding register and overrun flag.
// Define SIPO_RX_PARITY_EN to append an even-parity bit to each frame and expose parity_err.
module sipo_rx
    import sipo_pkg::*;
#(
    parameter int WIDTH = SIPO_WIDTH,
    parameter int CNT_W = $clog2(WIDTH+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ser_in,
    input  logic             shen,
    input  logic             resync,
    output logic [WIDTH-1:0] sreg,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_rd,
    output logic             overrun,
`ifdef SIPO_RX_PARITY_EN
    output logic             parity_err,
`endif
    output logic [CNT_W-1:0] bit_cnt
);

`ifdef SIPO_RX_PARITY_EN
    localparam int LAST = WIDTH;
`else
    localparam int LAST = WIDTH-1;
`endif

    logic             tc, shift, capture, done;
    logic [WIDTH-1:0] word;
    hold_st_t         state;

    assign shift = shen & ~resync;
    assign done  = shift & tc;

`ifdef SIPO_RX_PARITY_EN
    // The trailing parity bit is consumed by the counter but never enters sreg.
    assign capture = shift & (bit_cnt != CNT_W'(WIDTH));
    assign word    = sreg;
`else
    assign capture = shift;
    assign word    = {sreg[WIDTH-2:0], ser_in};
`endif

    sipo_bitcnt #(.MAX(LAST), .CNT_W(CNT_W)) u_bitcnt (
        .clk (clk),
        .rst (rst),
        .clr (resync),
        .en  (shen),
        .cnt (bit_cnt),
        .tc  (tc)
    );

    always_ff @(posedge clk) begin
        if (rst || resync)
            sreg <= '0;
        else if (capture)
            sreg <= {sreg[WIDTH-2:0], ser_in};
    end

    assign data_valid = state == ST_FULL;

    // A read in the completing cycle frees the slot, so the new word is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_EMPTY;
            data_out <= '0;
            overrun  <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else if (done) begin
            if (state == ST_EMPTY || data_rd) begin
                data_out <= word;
                state    <= ST_FULL;
`ifdef SIPO_RX_PARITY_EN
                parity_err <= even_parity(64'(sreg)) ^ ser_in;
`endif
            end else begin
                overrun <= 1'b1;
            end
        end else if (data_rd) begin
            state <= ST_EMPTY;
        end
    end

endmodule

// File: tb/tb_sipo_rx.sv
// tb_sipo_rx: scoreboard bench for sipo_rx; honours SIPO_RX_PARITY_EN when defined.
module tb_sipo_rx;

`ifdef SIPO_RX_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clk = 0, rst = 1, ser_in = 0, shen = 0, resync = 0, data_rd = 0;
    logic [7:0] sreg, data_out;
    logic       data_valid, overrun;
    logic [3:0] bit_cnt;
`ifdef SIPO_RX_PARITY_EN
    logic       parity_err;
`endif

    int         tests = 0, fails = 0;
    logic [7:0] exp_q[$];
    bit         m_full = 0;
    logic       pv = 0;
    logic [7:0] po = 0;

    sipo_rx #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .ser_in     (ser_in),
        .shen       (shen),
        .resync     (resync),
        .sreg       (sreg),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_rd    (data_rd),
        .overrun    (overrun),
`ifdef SIPO_RX_PARITY_EN
        .parity_err (parity_err),
`endif
        .bit_cnt    (bit_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1;
        repeat (n) tick();
        rst = 0;
        exp_q.delete();
        m_full = 0;
    endtask

    task automatic send_word(input logic [7:0] w, input int gap_at, input bit rd_last, input bit par);
        logic [8:0] f;
        f = {w, par};
        for (int i = 0; i < NB; i++) begin
            if (gap_at > 0 && i == gap_at) begin
                shen = 0;
                repeat (3) begin
                    tick();
                    check("gap_hold", 32'(bit_cnt), gap_at);
                end
            end
            shen    = 1;
            ser_in  = f[8-i];
            data_rd = (i == NB-1) ? rd_last : 1'b0;
            if (i == NB-1 && (!m_full || rd_last)) begin
                exp_q.push_back(w);
                m_full = 1;
            end
            tick();
        end
        shen    = 0;
        data_rd = 0;
    endtask

    task automatic send_partial(input logic [7:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            shen   = 1;
            ser_in = w[7-i];
            tick();
        end
        shen = 0;
    endtask

    task automatic read_word;
        data_rd = 1;
        tick();
        data_rd = 0;
        m_full  = 0;
        check("rd_clears_valid", 32'(data_valid), 0);
    endtask

    // Every new valid word or data_out change must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && data_valid && (!pv || data_out != po)) begin
            if (exp_q.size() == 0)
                check("spurious_valid", 32'(data_valid), 0);
            else
                check("word", 32'(data_out), 32'(exp_q.pop_front()));
        end
        pv <= data_valid;
        po <= data_out;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        shen   = 1;
        ser_in = 1;
        do_reset(5);
        shen   = 0;
        ser_in = 0;
        check("rst_sreg", 32'(sreg), 0);
        check("rst_data_out", 32'(data_out), 0);
        check("rst_valid", 32'(data_valid), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_bit_cnt", 32'(bit_cnt), 0);
`ifdef SIPO_RX_PARITY_EN
        check("rst_parity_err", 32'(parity_err), 0);
`endif

        send_word(8'h55, 0, 0, 0);
        check("single_valid", 32'(data_valid), 1);
        check("single_data", 32'(data_out), 32'h55);
        check("single_bit_cnt", 32'(bit_cnt), 0);
`ifdef SIPO_RX_PARITY_EN
        check("parity_ok", 32'(parity_err), 0);
`endif
        read_word();

        send_word(8'hA3, 4, 0, 0);
        check("gap_data", 32'(data_out), 32'hA3);
        read_word();

        send_word(8'h0F, 0, 0, 0);
        send_word(8'hF0, 0, 0, 0);
        check("ovr_data_kept", 32'(data_out), 32'h0F);
        check("ovr_flag", 32'(overrun), 1);
        check("ovr_valid", 32'(data_valid), 1);

        do_reset(1);
        send_word(8'h0F, 0, 0, 0);
        send_word(8'hF0, 0, 1, 0);
        check("rdhit_data", 32'(data_out), 32'hF0);
        check("rdhit_no_ovr", 32'(overrun), 0);
        check("rdhit_valid", 32'(data_valid), 1);
        read_word();

        send_partial(8'hFF, 5);
        check("partial_cnt", 32'(bit_cnt), 5);
        resync = 1;
        tick();
        resync = 0;
        check("resync_cnt", 32'(bit_cnt), 0);
        check("resync_sreg", 32'(sreg), 0);
        check("resync_no_valid", 32'(data_valid), 0);
        send_word(8'h3C, 0, 0, 0);
        check("resync_data", 32'(data_out), 32'h3C);
        read_word();

        send_partial(8'hFF, 5);
        do_reset(1);
        check("midrst_cnt", 32'(bit_cnt), 0);
        check("midrst_no_valid", 32'(data_valid), 0);
        send_word(8'h3C, 0, 0, 0);
        check("midrst_data", 32'(data_out), 32'h3C);
        read_word();

`ifdef SIPO_RX_PARITY_EN
        send_word(8'h55, 0, 0, 1);
        check("parity_bad", 32'(parity_err), 1);
        check("parity_data", 32'(data_out), 32'h55);
        read_word();
`endif

        tick();
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
